// File: rtl/key_debouncer.sv
// key_debouncer: multi-channel key debouncer sampling raw keys on rising edges of a slow divider tick,
// producing clean levels plus one-cycle press/release strobes, all in the clkin domain.
module key_debouncer #(
  parameter int WIDTH          = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);
  localparam int CW = STABLE_SAMPLES > 1 ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [CW-1:0] last = CW'(STABLE_SAMPLES - 1);
  localparam logic rel = ACTIVE_LOW != 0;
  logic [WIDTH-1:0] sync1, sync2, s;
  logic             tick_q, strobe;
  logic [CW-1:0]    cnt [WIDTH];
  always_comb begin
    s = rel ? ~sync2 : sync2;
    strobe = tick & ~tick_q;
  end
  // tick_q resets high so a tick already high at reset release is not an edge
  always_ff @(posedge clkin) begin
    if (rst) begin
      sync1       <= {WIDTH{rel}};
      sync2       <= {WIDTH{rel}};
      tick_q      <= 1'b1;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1       <= key_raw;
      sync2       <= sync1;
      tick_q      <= tick;
      key_press   <= '0;
      key_release <= '0;
      if (strobe)
        for (int i = 0; i < WIDTH; i++)
          if (s[i] == key_level[i]) cnt[i] <= '0;
          else if (cnt[i] == last) begin
            key_level[i]   <= s[i];
            key_press[i]   <= s[i];
            key_release[i] <= ~s[i];
            cnt[i]         <= '0;
          end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed plus random stimulus on two configurations, checked every cycle
// against a sample-history model of the debounce rule.
module tb_key_debouncer;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b1;
  logic [3:0] raw0 = 4'hF, raw1 = 4'h0;
  logic [3:0] lev0, pr0, rl0, lev1, pr1, rl1;
  always #5 clk = ~clk;
  key_debouncer #(.WIDTH(4), .STABLE_SAMPLES(4), .ACTIVE_LOW(1)) u0 (
    .clkin(clk), .rst(rst), .tick(tick), .key_raw(raw0),
    .key_level(lev0), .key_press(pr0), .key_release(rl0));
  key_debouncer #(.WIDTH(4), .STABLE_SAMPLES(1), .ACTIVE_LOW(0)) u1 (
    .clkin(clk), .rst(rst), .tick(tick), .key_raw(raw1),
    .key_level(lev1), .key_press(pr1), .key_release(rl1));
  int total = 0, bad = 0;
  int np0[4] = '{0, 0, 0, 0}, nr0[4] = '{0, 0, 0, 0};
  int np1 = 0;
  bit saw1100 = 0, valid = 0;
  int ns[2] = '{4, 1};
  bit al[2] = '{1'b1, 1'b0};
  logic [3:0] m1[2], m2[2], ml[2], mp[2], mr[2];
  logic mtq;
  int hc[2][4];
  logic [15:0] hb[2][4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a level flips once the last N strobe samples since reset/acceptance all differ from it
  always @(posedge clk) begin : model
    logic [3:0] s;
    logic st;
    bit ok;
    if (rst) begin
      valid = 1;
      mtq = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m1[i] = {4{al[i]}};
        m2[i] = {4{al[i]}};
        ml[i] = '0;
        mp[i] = '0;
        mr[i] = '0;
        for (int c = 0; c < 4; c++) hc[i][c] = 0;
      end
    end else if (valid) begin
      st = tick & ~mtq;
      for (int i = 0; i < 2; i++) begin
        s = al[i] ? ~m2[i] : m2[i];
        mp[i] = '0;
        mr[i] = '0;
        if (st)
          for (int c = 0; c < 4; c++) begin
            hb[i][c] = {hb[i][c][14:0], s[c]};
            if (hc[i][c] < 16) hc[i][c]++;
            ok = hc[i][c] >= ns[i];
            for (int k = 0; k < ns[i]; k++) if (hb[i][c][k] == ml[i][c]) ok = 0;
            if (ok) begin
              ml[i][c] = s[c];
              mp[i][c] = s[c];
              mr[i][c] = ~s[c];
              hc[i][c] = 0;
            end
          end
        m2[i] = m1[i];
        m1[i] = i == 0 ? raw0 : raw1;
      end
      mtq = tick;
    end
    #1;
    if (valid) begin
      chk("u0_outputs", {20'd0, lev0, pr0, rl0}, {20'd0, ml[0], mp[0], mr[0]});
      chk("u1_outputs", {20'd0, lev1, pr1, rl1}, {20'd0, ml[1], mp[1], mr[1]});
      for (int c = 0; c < 4; c++) begin
        np0[c] += int'(pr0[c]);
        nr0[c] += int'(rl0[c]);
      end
      np1 += int'(pr1[0]);
      if (pr0 == 4'b1100) saw1100 = 1;
    end
  end
  task automatic hold(input logic t, input int n);
    for (int j = 0; j < n; j++) begin
      tick = t;
      @(negedge clk);
    end
  endtask
  task automatic per();
    hold(1'b0, 4);
    hold(1'b1, 4);
  endtask
  initial begin
    logic [6:0] bounce;
    bounce = 7'b0000100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 20);
    chk("t1_level", {28'd0, lev0}, 32'd0);
    chk("t1_pulses", np0[0] + np0[1] + np0[2] + np0[3] + nr0[0] + nr0[1] + nr0[2] + nr0[3], 32'd0);
    raw0 = 4'b1110;
    repeat (3) per();
    chk("t2_press_early", np0[0], 32'd0);
    per();
    chk("t2_press", np0[0], 32'd1);
    chk("t2_level", {28'd0, lev0}, 32'd1);
    raw0 = 4'b1111;
    repeat (3) per();
    chk("t4_release_early", nr0[0], 32'd0);
    per();
    chk("t4_release", nr0[0], 32'd1);
    chk("t4_level", {28'd0, lev0}, 32'd0);
    chk("t4_no_press", np0[0], 32'd1);
    for (int k = 0; k < 7; k++) begin
      raw0[1] = bounce[k];
      per();
      if (k == 5) chk("t3_press_early", np0[1], 32'd0);
    end
    chk("t3_press", np0[1], 32'd1);
    chk("t3_level", {28'd0, lev0}, 32'd2);
    raw0 = 4'b0001;
    repeat (4) per();
    chk("t5_both", {31'd0, saw1100}, 32'd1);
    chk("t5_level", {28'd0, lev0}, 32'hE);
    raw0 = 4'b0101;
    repeat (3) per();
    hold(1'b0, 4);
    tick = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_reset_out", {20'd0, lev0, pr0, rl0}, 32'd0);
    chk("t5_no_release", nr0[2], 32'd0);
    hold(1'b1, 3);
    raw1 = 4'b0001;
    chk("t6_press_early", np1, 32'd0);
    per();
    chk("t6_press", np1, 32'd1);
    chk("t6_level", {28'd0, lev1}, 32'd1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) tick = ~tick;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, (n % 400) < 100 ? 7 : 63) == 0) raw0[c] = ~raw0[c];
        if ($urandom_range(0, (n % 400) < 100 ? 7 : 63) == 0) raw1[c] = ~raw1[c];
      end
      rst = $urandom_range(0, 299) == 0;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_debouncer.md
# key_debouncer

Multi-channel push-button debouncer that consumes the slow square wave produced by the team's debounce clock divider. It samples each raw key on the divider's rising edges and accepts a new key level only after it has been stable for a programmable number of consecutive samples. It produces clean per-key levels plus single-cycle press and release strobes for the control FSMs. The block runs entirely in the system clock domain: the divider output is treated as data, never as a clock.

## Interface
- `WIDTH`, 4: number of independent key channels (1..16).
- `STABLE_SAMPLES`, 4: consecutive equal samples required to accept a change (1..16).
- `ACTIVE_LOW`, 1: 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed.

- `clkin`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `tick`, input, 1: slow square wave from the debounce divider, synchronous to `clkin`.
- `key_raw`, input, WIDTH: asynchronous raw key pins.
- `key_level`, output, WIDTH: debounced logical level (1 = pressed), registered.
- `key_press`, output, WIDTH: one-cycle strobe on an accepted 0→1 transition of `key_level`.
- `key_release`, output, WIDTH: one-cycle strobe on an accepted 1→0 transition of `key_level`.

## Operation
- **Synchronizer.** `key_raw` passes through two flip-flops per channel. The second stage is then inverted when `ACTIVE_LOW` = 1, giving the logical sample `s[i]` (1 = pressed).
- **Strobe generation.** `tick_q` registers `tick` each cycle. `strobe` = `tick & ~tick_q`, so there is exactly one strobe per divider period.
- **Per-channel counter.** Each channel has a counter `cnt[i]` of width clog2(STABLE_SAMPLES), minimum 1. Updates happen only on strobe cycles:
  - If `s[i]` == `key_level[i]`: `cnt[i]` ← 0.
  - If `s[i]` != `key_level[i]` and `cnt[i]` == STABLE_SAMPLES−1:
    - `key_level[i]` ← `s[i]`
    - `cnt[i]` ← 0
    - `key_press[i]` ← `s[i]`
    - `key_release[i]` ← ~`s[i]`
  - Otherwise: `cnt[i]` ← `cnt[i]`+1.
- **Non-strobe cycles.** `key_level` and `cnt` hold. `key_press` and `key_release` are 0.
- **Strobe width.** `key_press` and `key_release` are never high for more than one cycle. They are never both high on the same channel.
- **Channel independence.** Channels are independent. Several channels may strobe in the same cycle.
- **STABLE_SAMPLES = 1.** The first differing sample is accepted immediately.
- **Glitch rejection.** A sample equal to the current level clears the counter. A bounce therefore restarts the count, and counts never accumulate across a bounce.
- **Counter range.** `cnt` never exceeds STABLE_SAMPLES−1 and never wraps.

## Timing
- **Reset values:**
  - `key_level` = 0, `key_press` = 0, `key_release` = 0, `cnt` = 0.
  - Synchronizer flops = raw released value (1 if `ACTIVE_LOW`, else 0).
  - `tick_q` = 1. A `tick` that is already high when reset is released therefore does not produce a strobe; the first strobe needs a real 0→1 edge of `tick`.
- **Raw-to-sample latency.** A change on `key_raw` is visible in `s` 2 cycles later.
- **Strobe latency.** `strobe` is asserted in the cycle where `tick` = 1 and `tick_q` = 0, i.e. the first cycle `tick` is sampled high.
- **Acceptance latency.** A change is accepted on the STABLE_SAMPLES-th consecutive differing strobe. `key_level` and the press/release strobe update at the clock edge ending that strobe cycle and are visible for the following cycle. The strobe lasts exactly one cycle.
- **Worst-case acceptance delay.** After the raw input settles, the change is accepted within 2 + STABLE_SAMPLES × (tick period in clkin cycles) + 1 cycles.
- **Reset mid-count.** `rst` asserted on any cycle, including a strobe cycle, overrides all updates. Outputs are at reset values on the next cycle and no pulse is emitted.
- **`tick` held constant** (high or low): no strobes, and all state holds.

## Test plan
1. **Reset with `tick` high.** Reset with `tick` = 1 and `key_raw` = 4'b1111 (`ACTIVE_LOW` = 1), then hold `tick` high for 20 cycles → all outputs stay 0, no strobes.
2. **Clean press.** `key_raw[0]` → 0 and held; `tick` period 8 cycles; `STABLE_SAMPLES` = 4 → `key_press` = 4'b0001 for exactly one cycle, in the cycle after the 4th strobe following synchronization; `key_level` = 4'b0001 from then on.
3. **Bounce rejection.** On channel 1, drive the pattern press, press, release, press, press, press, press across successive strobes → no press after the 2nd strobe (counter cleared by the release). The press is accepted at the 7th strobe only; exactly one `key_press[1]` pulse.
4. **Release.** From `key_level` = 4'b0001, return `key_raw[0]` to 1 → `key_release` = 4'b0001 for one cycle after 4 stable strobes; `key_level` = 0. No `key_press` pulse during this.
5. **Simultaneous channels.** Press channels 2 and 3 in the same cycle → `key_press` = 4'b1100 in a single cycle. Then assert `rst` on the strobe cycle where channel 2 would release → no release pulse; all outputs 0 next cycle.
6. **Immediate acceptance with `ACTIVE_LOW` = 0.** `STABLE_SAMPLES` = 1, `ACTIVE_LOW` = 0; `key_raw[0]` → 1 → press pulse after the first strobe following the 2-cycle synchronizer.
